// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART line-format constants and receiver state type
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - multi-flop synchroniser for a single asynchronous input
module uart_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ff <= {STAGES{RESET_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and valid/ack byte handoff
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       Rx,
    output logic [7:0] data_out,
    output logic       byte_valid_o,
    input  logic       byte_ack_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 rx_s;
    logic                 rx_prev;
    logic                 sample;
    logic                 commit;
    logic                 frame_bad;

    uart_sync #(
        .STAGES   (SYNC_STAGES),
        .RESET_VAL(IDLE_LEVEL)
    ) u_sync (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .d      (Rx),
        .q      (rx_s)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state   <= IDLE;
            rx_prev <= IDLE_LEVEL;
        end else begin
            state   <= state_nxt;
            rx_prev <= rx_s;
        end
    end

    // Only a falling edge leaves IDLE, so a line stuck low (break) cannot retrigger.
    always_comb begin
        state_nxt = state;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_prev == IDLE_LEVEL && rx_s == START_BIT) state_nxt = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    sample    = 1'b1;
                    state_nxt = (rx_s == START_BIT) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    sample = 1'b1;
                    if (bit_idx == IDX_LAST) state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    sample    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign commit    = (state == STOP) && sample && (rx_s == STOP_BIT);
    assign frame_bad = (state == STOP) && sample && (rx_s != STOP_BIT);
    assign busy_o    = (state != IDLE);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            if (state == IDLE || sample) cnt <= '0;
            else                         cnt <= cnt + 1'b1;

            if (state != DATA)           bit_idx <= '0;
            else if (sample)             bit_idx <= bit_idx + 1'b1;

            if (state == DATA && sample) shift[bit_idx] <= rx_s;
        end
    end

    // A commit outranks an ack arriving in the same cycle: the new byte stays valid.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            data_out     <= 8'h00;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            frame_err_o <= frame_bad;
            overrun_o   <= 1'b0;
            if (commit) begin
                data_out     <= shift;
                byte_valid_o <= 1'b1;
                overrun_o    <= byte_valid_o && !byte_ack_i;
            end else if (byte_ack_i) begin
                byte_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int SYN = 2;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       Rx = 1'b1;
    logic [7:0] data_out;
    logic       byte_valid_o;
    logic       byte_ack_i = 1'b0;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    int valid_cycles, fe_cycles, ov_cycles, busy_cycles;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYN)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .Rx          (Rx),
        .data_out    (data_out),
        .byte_valid_o(byte_valid_o),
        .byte_ack_i  (byte_ack_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Observation only: counts and records what the DUT presents at each negedge.
    always @(negedge clk_i) begin
        if (byte_valid_o) valid_cycles++;
        if (frame_err_o)  fe_cycles++;
        if (overrun_o)    ov_cycles++;
        if (busy_o)       busy_cycles++;
        if (byte_valid_o && byte_ack_i) rx_q.push_back(data_out);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic clr();
        valid_cycles = 0;
        fe_cycles    = 0;
        ov_cycles    = 0;
        busy_cycles  = 0;
        rx_q.delete();
        exp_q.delete();
    endtask

    // Behavioural transmitter: start, 8 data bits LSB first, stop, each CPB cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        Rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            Rx = (b >> i) & 8'h01;
            tick(CPB);
        end
        Rx = stop_lvl;
        tick(CPB);
    endtask

    task automatic check_q(input string name);
        n_checks++;
        if (rx_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s count: got %0d bytes, expected %0d", name, rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL %s byte[%0d]: got %h, expected %h", name, i, rx_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_checks++;
        if ({data_out, byte_valid_o, frame_err_o, overrun_o, busy_o} !== 12'h000) begin
            n_fail++;
            $display("FAIL %s: data_out=%h valid=%b fe=%b ov=%b busy=%b, expected all zero",
                     name, data_out, byte_valid_o, frame_err_o, overrun_o, busy_o);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        Rx = 1'b1;
        #23;
        check_outputs_zero("reset_state");
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        tick(5);
        check_outputs_zero("after_release");
    endtask

    task automatic test_single_ack_high();
        byte_ack_i = 1'b1;
        clr();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        tick(6);
        n_checks++;
        if (valid_cycles !== 1) begin
            n_fail++;
            $display("FAIL single_valid_width: got %0d cycles, expected 1", valid_cycles);
        end
        n_checks++;
        if (data_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_data: got %h, expected a5", data_out);
        end
        n_checks++;
        if (fe_cycles !== 0 || ov_cycles !== 0) begin
            n_fail++;
            $display("FAIL single_errors: fe=%0d ov=%0d, expected 0 0", fe_cycles, ov_cycles);
        end
        check_q("single");
    endtask

    task automatic test_loopback_back_to_back();
        byte_ack_i = 1'b1;
        clr();
        exp_q.push_back(8'hAA);
        send_frame(8'hAA, 1'b1);
        tick(4);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(6);
        check_q("loopback");
        n_checks++;
        if (fe_cycles !== 0 || ov_cycles !== 0) begin
            n_fail++;
            $display("FAIL loopback_errors: fe=%0d ov=%0d, expected 0 0", fe_cycles, ov_cycles);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        byte_ack_i = 1'b1;
        clr();
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            tick($urandom_range(0, 20));
        end
        tick(6);
        check_q("random");
    endtask

    task automatic test_glitch();
        byte_ack_i = 1'b1;
        clr();
        Rx = 1'b0;
        tick(3);
        Rx = 1'b1;
        tick(3 * CPB);
        n_checks++;
        if (busy_cycles < CPB / 2 - 2 || busy_cycles > CPB / 2 + 2) begin
            n_fail++;
            $display("FAIL glitch_busy: got %0d busy cycles, expected about %0d", busy_cycles, CPB / 2);
        end
        n_checks++;
        if (valid_cycles !== 0 || fe_cycles !== 0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_quiet: valid=%0d fe=%0d busy=%b, expected 0 0 0",
                     valid_cycles, fe_cycles, busy_o);
        end
    endtask

    task automatic test_frame_error();
        logic [7:0] prev;
        byte_ack_i = 1'b1;
        tick(2);
        prev = data_out;
        clr();
        send_frame(8'h3C, 1'b0);
        tick(2);
        n_checks++;
        if (fe_cycles !== 1) begin
            n_fail++;
            $display("FAIL frame_err_pulse: got %0d cycles, expected 1", fe_cycles);
        end
        n_checks++;
        if (valid_cycles !== 0 || data_out !== prev) begin
            n_fail++;
            $display("FAIL frame_err_hold: valid=%0d data=%h, expected 0 and %h", valid_cycles, data_out, prev);
        end
        busy_cycles = 0;
        tick(4 * CPB);
        n_checks++;
        if (busy_cycles !== 0) begin
            n_fail++;
            $display("FAIL break_no_retrigger: got %0d busy cycles, expected 0", busy_cycles);
        end
        Rx = 1'b1;
        tick(4);
        clr();
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        tick(6);
        check_q("after_break");
    endtask

    task automatic test_overrun();
        byte_ack_i = 1'b0;
        clr();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(6);
        n_checks++;
        if (ov_cycles !== 1) begin
            n_fail++;
            $display("FAIL overrun_pulse: got %0d cycles, expected 1", ov_cycles);
        end
        n_checks++;
        if (data_out !== 8'h22 || byte_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_data: data=%h valid=%b, expected 22 1", data_out, byte_valid_o);
        end
        byte_ack_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (byte_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_not_early: valid=%b, expected 1 before the edge", byte_valid_o);
        end
        @(posedge clk_i);
        #1;
        byte_ack_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (byte_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_clear: valid=%b, expected 0", byte_valid_o);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h5A;
        byte_ack_i = 1'b0;
        clr();
        Rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            Rx = (b >> i) & 8'h01;
            tick(CPB);
        end
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_frame_busy: got %b, expected 1", busy_o);
        end
        #2;
        reset_i = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        Rx = 1'b1;
        tick(3);
        reset_i = 1'b1;
        tick(4);
        clr();
        send_frame(8'hC3, 1'b1);
        tick(6);
        n_checks++;
        if (data_out !== 8'hC3 || byte_valid_o !== 1'b1 || ov_cycles !== 0 || fe_cycles !== 0) begin
            n_fail++;
            $display("FAIL post_reset_frame: data=%h valid=%b ov=%0d fe=%0d, expected c3 1 0 0",
                     data_out, byte_valid_o, ov_cycles, fe_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_single_ack_high();
        test_loopback_back_to_back();
        test_random();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
